// File: rtl/circuit_sched_if.sv
// Request/response bundle between the requesters and circuit_sched.
// The master side is the requester population; the slave side is the scheduler.
interface circuit_sched_if #(
    parameter int W     = 32,
    parameter int N_REQ = 4
);
    localparam int IW = $clog2(N_REQ);

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*32-1:0] req_x;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    resp_valid;
    logic [N_REQ-1:0]    resp_ready;
    logic [W-1:0]        resp_y;
    logic [IW-1:0]       resp_id;

    modport master (
        output req_valid, req_x, resp_ready,
        input  req_ready, resp_valid, resp_y, resp_id
    );

    modport slave (
        input  req_valid, req_x, resp_ready,
        output req_ready, resp_valid, resp_y, resp_id
    );
endinterface

// File: rtl/circuit_sched.sv
// Shares one iterative circuit datapath between N_REQ requesters: clear, run N_ITER cycles, return result.
// Define CIRCUIT_SCHED_PRIO_EN for fixed-priority arbitration instead of round-robin.
module circuit_sched #(
    parameter int W      = 32,
    parameter int N_REQ  = 4,
    parameter int N_ITER = 100
) (
    input  logic          clk,
    input  logic          rst,
    circuit_sched_if.slave bus,
    output logic          busy,
    output logic          dp_rst,
    output logic          dp_en,
    output logic [31:0]   dp_x,
    input  logic [W-1:0]  dp_y
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(N_ITER + 1);

    // state | meaning
    // IDLE  | arbitrate pending requests, accept one job
    // CLR   | hold datapath in reset, clear iteration counter
    // RUN   | datapath enabled for N_ITER cycles
    // CAPT  | register datapath result
    // RESP  | present result to owner until it accepts
    typedef enum logic [2:0] {IDLE, CLR, RUN, CAPT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   grant;
    logic            found;
    logic [IW-1:0]   owner;
    logic [31:0]     operand;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    resp_y_q;
`ifndef CIRCUIT_SCHED_PRIO_EN
    logic [IW-1:0]   last;
`endif

`ifdef CIRCUIT_SCHED_PRIO_EN
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req_valid[i]) begin
                grant = IW'(i);
                found = 1'b1;
            end
        end
    end
`else
    // Scan upward from the slot after the last winner, wrapping at N_REQ.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!found && bus.req_valid[idx[IW-1:0]]) begin
                grant = idx[IW-1:0];
                found = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = CLR;
            CLR:     state_nxt = RUN;
            RUN:     if (cnt == CW'(N_ITER - 1)) state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (bus.resp_ready[owner]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operand  <= '0;
            owner    <= '0;
            cnt      <= '0;
            resp_y_q <= '0;
`ifndef CIRCUIT_SCHED_PRIO_EN
            last     <= IW'(N_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    operand <= bus.req_x[32*int'(grant) +: 32];
                    owner   <= grant;
`ifndef CIRCUIT_SCHED_PRIO_EN
                    last    <= grant;
`endif
                end
                CLR:  cnt <= '0;
                RUN:  if (cnt != CW'(N_ITER - 1)) cnt <= cnt + CW'(1);
                CAPT: resp_y_q <= dp_y;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.req_ready  = (state == IDLE && found) ? (N_REQ'(1) << grant) : '0;
        bus.resp_valid = (state == RESP) ? (N_REQ'(1) << owner) : '0;
        bus.resp_id    = (state == RESP) ? owner : '0;
        bus.resp_y     = resp_y_q;
        busy           = (state != IDLE);
        dp_rst         = rst || (state == CLR);
        dp_en          = (state == RUN);
        dp_x           = (state != IDLE) ? operand : 32'd0;
    end
endmodule

// File: tb/tb_circuit_sched.sv
// Directed bench for circuit_sched with an accumulating datapath stub (dp_y = sum of dp_x over enabled cycles).
module tb_circuit_sched;
    localparam int W = 32;
    localparam int N_REQ = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy, dp_rst, dp_en;
    logic [31:0]   dp_x;
    logic [W-1:0]  dp_y;
    logic [W-1:0]  acc;

    int passed = 0;
    int failed = 0;
    int total  = 0;

    circuit_sched_if #(.W(W), .N_REQ(N_REQ)) bus ();

    circuit_sched #(.W(W), .N_REQ(N_REQ), .N_ITER(100)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus.slave),
        .busy   (busy),
        .dp_rst (dp_rst),
        .dp_en  (dp_en),
        .dp_x   (dp_x),
        .dp_y   (dp_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dp_rst)     acc <= '0;
        else if (dp_en) acc <= acc + dp_x;
    end
    assign dp_y = acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int k, en_cnt, cyc, ng;
        logic stable, noresp;
        logic [N_REQ-1:0] g [5];
        int t [5];
        logic [N_REQ-1:0] exp_g [5];
`ifdef CIRCUIT_SCHED_PRIO_EN
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        for (int i = 0; i < 5; i++) begin g[i] = '0; t[i] = 0; end

        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_x = '0;
        bus.resp_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_y", bus.resp_y, 0);
        check("rst_resp_id", bus.resp_id, 0);
        check("rst_dp_rst", dp_rst, 1);
        check("rst_dp_en", dp_en, 0);
        check("rst_dp_x", dp_x, 0);
        rst = 1'b0;
        #1;
        check("rel_dp_rst", dp_rst, 0);

        // Single job from requester 2, x = 5
        bus.req_x = {32'd0, 32'd5, 32'd0, 32'd0};
        bus.req_valid = 4'b0100;
        #1;
        check("single_req_ready", bus.req_ready, 4'b0100);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        check("clr_busy", busy, 1);
        check("clr_dp_rst", dp_rst, 1);
        check("clr_dp_x", dp_x, 5);
        check("clr_req_ready", bus.req_ready, 0);
        k = 1;
        en_cnt = 0;
        while (bus.resp_valid == '0 && k < 200) begin
            en_cnt += int'(dp_en);
            @(posedge clk);
            #1;
            k++;
        end
        check("resp_latency", k, 103);
        check("en_cycles", en_cnt, 100);
        check("resp_valid", bus.resp_valid, 4'b0100);
        check("resp_id", bus.resp_id, 2);
        check("resp_y", bus.resp_y, 500);

        // Backpressure; non-owner ready and a new pending request must be ignored
        bus.req_valid = 4'b0001;
        bus.resp_ready = 4'b1011;
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid !== 4'b0100 || bus.resp_id !== 2'd2 ||
                bus.resp_y !== 32'd500 || bus.req_ready !== 4'b0000) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        bus.resp_ready = 4'b0100;
        @(posedge clk);
        #1;
        check("bp_release_busy", busy, 0);
        check("bp_release_valid", bus.resp_valid, 0);
        check("pending_grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        bus.resp_ready = '0;
        #1;
        check("withdraw_ready", bus.req_ready, 0);
        @(posedge clk);
        #1;
        check("withdraw_idle", busy, 0);

        // Reset in the middle of RUN
        bus.req_x = {32'd9, 32'd0, 32'd0, 32'd0};
        bus.req_valid = 4'b1000;
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        repeat (51) @(posedge clk);
        #1;
        check("run50_en", dp_en, 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_dp_en", dp_en, 0);
        check("abort_dp_rst", dp_rst, 1);
        check("abort_busy", busy, 0);
        check("abort_dp_x", dp_x, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        noresp = 1'b1;
        repeat (110) begin
            @(posedge clk);
            #1;
            if (bus.resp_valid !== '0 || busy !== 1'b0) noresp = 1'b0;
        end
        check("abort_no_resp", noresp, 1);

        // Contention: all requesters pending, responses always accepted
        bus.req_x = {32'd4, 32'd3, 32'd2, 32'd1};
        bus.req_valid = 4'b1111;
        bus.resp_ready = 4'b1111;
        #1;
        cyc = 0;
        ng = 0;
        while (ng < 5 && cyc < 700) begin
            if (bus.req_ready != '0) begin
                g[ng] = bus.req_ready;
                t[ng] = cyc;
                ng++;
            end
            if (ng < 5) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        bus.req_valid = '0;
        check("rr_grant_count", ng, 5);
        for (int i = 0; i < 5; i++) check($sformatf("rr_grant_%0d", i), g[i], exp_g[i]);
        for (int i = 0; i < 4; i++) check($sformatf("rr_gap_%0d", i), t[i+1] - t[i], 104);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
